// File: rtl/i2s_clk_gen.sv
// I2S/TDM clock generator: derives SCKI, BCK and LRCK/frame-sync from mck and exports bit/slot position.
// Optional frame counter output enabled by defining I2S_CLK_GEN_FRAME_CNT_EN.
module i2s_clk_gen #(
  parameter int unsigned SCKI_DIV_LOG2 = 0,
  parameter int unsigned SLOT_BITS     = 32,
  parameter int unsigned CHANNELS      = 2,
  parameter logic [1:0]  BCK_SEL_RST   = 2'd1
) (
  input  logic                                                mck,
  input  logic                                                reset,
  input  logic                                                en,
  input  logic [1:0]                                          bck_sel,
  output logic                                                scki,
  output logic                                                bck,
  output logic                                                lrck,
  output logic                                                frame_start,
  output logic [((CHANNELS > 2) ? $clog2(CHANNELS) : 1)-1:0] slot_idx,
  output logic [$clog2(SLOT_BITS)-1:0]                        bit_idx,
  output logic [1:0]                                          sel_active
`ifdef I2S_CLK_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]                                         frame_cnt
`endif
);

  localparam int SW  = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam int BW  = $clog2(SLOT_BITS);
  localparam int SCW = (SCKI_DIV_LOG2 > 0) ? SCKI_DIV_LOG2 : 1;
  localparam logic [SCW-1:0] SC_LAST   = SCW'((1 << SCKI_DIV_LOG2) - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(CHANNELS - 1);

  logic           run_q, run_d;
  logic           scki_q, scki_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [5:0]     div_q, div_d;
  logic           bck_q, bck_d;
  logic           lrck_q, lrck_d;
  logic           fs_q, fs_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [1:0]     sel_q, sel_d;
  logic [15:0]    fcnt_q, fcnt_d;

  logic [6:0]     two_h, last, half_m1;

  // Stereo: lrck follows slot parity. TDM: one-slot-wide sync pulse in slot 0.
  function automatic logic lrck_of(input logic [SW-1:0] s);
    if (CHANNELS == 2) return s[0];
    else               return (s == '0);
  endfunction

  always_comb begin
    two_h   = 7'd4 << sel_q;
    last    = two_h - 7'd1;
    half_m1 = (two_h >> 1) - 7'd1;
  end

  always_comb begin
    run_d  = run_q;
    scki_d = scki_q;
    scnt_d = scnt_q;
    div_d  = div_q;
    bck_d  = bck_q;
    lrck_d = lrck_q;
    fs_d   = 1'b0;
    slot_d = slot_q;
    bit_d  = bit_q;
    sel_d  = sel_q;
    fcnt_d = fcnt_q;
    if (!en) begin
      run_d  = 1'b0;
      scki_d = 1'b0;
      scnt_d = '0;
      div_d  = '0;
      bck_d  = 1'b0;
      lrck_d = 1'b0;
      slot_d = '0;
      bit_d  = '0;
      sel_d  = BCK_SEL_RST;
      fcnt_d = '0;
    end else begin
      run_d = 1'b1;
      if (scnt_q == SC_LAST) begin
        scnt_d = '0;
        scki_d = ~scki_q;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
      if (!run_q) begin
        // First enabled edge: idle counts as the falling edge of bit 0, slot 0.
        sel_d  = bck_sel;
        fs_d   = 1'b1;
        div_d  = 6'd1;
        bck_d  = 1'b0;
        bit_d  = '0;
        slot_d = '0;
        lrck_d = lrck_of('0);
      end else if ({1'b0, div_q} == last) begin
        div_d = '0;
        bck_d = 1'b0;
        if (bit_q == BIT_LAST) begin
          bit_d = '0;
          if (slot_q == SLOT_LAST) begin
            // Ratio changes only here, so the new H starts with a full low phase.
            slot_d = '0;
            fs_d   = 1'b1;
            sel_d  = bck_sel;
          end else begin
            slot_d = slot_q + 1'b1;
          end
          lrck_d = lrck_of(slot_d);
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end else begin
        div_d = div_q + 6'd1;
        if ({1'b0, div_q} == half_m1) bck_d = 1'b1;
      end
      if (fs_d) fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge mck or posedge reset) begin
    if (reset) begin
      run_q  <= 1'b0;
      scki_q <= 1'b0;
      scnt_q <= '0;
      div_q  <= '0;
      bck_q  <= 1'b0;
      lrck_q <= 1'b0;
      fs_q   <= 1'b0;
      slot_q <= '0;
      bit_q  <= '0;
      sel_q  <= BCK_SEL_RST;
      fcnt_q <= '0;
    end else begin
      run_q  <= run_d;
      scki_q <= scki_d;
      scnt_q <= scnt_d;
      div_q  <= div_d;
      bck_q  <= bck_d;
      lrck_q <= lrck_d;
      fs_q   <= fs_d;
      slot_q <= slot_d;
      bit_q  <= bit_d;
      sel_q  <= sel_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign scki        = scki_q;
  assign bck         = bck_q;
  assign lrck        = lrck_q;
  assign frame_start = fs_q;
  assign slot_idx    = slot_q;
  assign bit_idx     = bit_q;
  assign sel_active  = sel_q;

`ifdef I2S_CLK_GEN_FRAME_CNT_EN
  assign frame_cnt = fcnt_q;
`else
  logic unused_fcnt;
  assign unused_fcnt = ^fcnt_q;
`endif

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Directed bench: stereo instance (32-bit slots) and TDM instance (8x16-bit slots, scki = mck/4).
module tb_i2s_clk_gen;

  logic       mck = 1'b0;
  logic       rst = 1'b1;
  logic       s_en = 1'b0, t_en = 1'b0;
  logic [1:0] s_sel = 2'd0, t_sel = 2'd0;

  logic       s_scki, s_bck, s_lrck, s_fs;
  logic [0:0] s_slot;
  logic [4:0] s_bit;
  logic [1:0] s_act;
  logic       t_scki, t_bck, t_lrck, t_fs;
  logic [2:0] t_slot;
  logic [3:0] t_bit;
  logic [1:0] t_act;
`ifdef I2S_CLK_GEN_FRAME_CNT_EN
  logic [15:0] s_fcnt, t_fcnt;
`endif

  int total = 0;
  int bad   = 0;
  int k     = 0;

  always #5 mck = ~mck;

  i2s_clk_gen #(.SCKI_DIV_LOG2(0), .SLOT_BITS(32), .CHANNELS(2), .BCK_SEL_RST(2'd1)) u_st (
    .mck(mck), .reset(rst), .en(s_en), .bck_sel(s_sel),
    .scki(s_scki), .bck(s_bck), .lrck(s_lrck), .frame_start(s_fs),
    .slot_idx(s_slot), .bit_idx(s_bit), .sel_active(s_act)
`ifdef I2S_CLK_GEN_FRAME_CNT_EN
    , .frame_cnt(s_fcnt)
`endif
  );

  i2s_clk_gen #(.SCKI_DIV_LOG2(1), .SLOT_BITS(16), .CHANNELS(8), .BCK_SEL_RST(2'd3)) u_tdm (
    .mck(mck), .reset(rst), .en(t_en), .bck_sel(t_sel),
    .scki(t_scki), .bck(t_bck), .lrck(t_lrck), .frame_start(t_fs),
    .slot_idx(t_slot), .bit_idx(t_bit), .sel_active(t_act)
`ifdef I2S_CLK_GEN_FRAME_CNT_EN
    , .frame_cnt(t_fcnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k = number of rising edges since the first enabled edge; sampled on falling edges
  task automatic adv_to(input int target);
    while (k < target) begin
      @(negedge mck);
      k++;
    end
  endtask

  initial begin
    @(negedge mck);
    chk("rst_s_scki", s_scki, 0);
    chk("rst_s_bck",  s_bck,  0);
    chk("rst_s_lrck", s_lrck, 0);
    chk("rst_s_fs",   s_fs,   0);
    chk("rst_s_slot", s_slot, 0);
    chk("rst_s_bit",  s_bit,  0);
    chk("rst_s_sel",  s_act,  1);
    chk("rst_t_sel",  t_act,  3);
    rst = 1'b0;
    repeat (3) @(negedge mck);
    chk("idle_s_sel", s_act, 1);
    chk("idle_s_fs",  s_fs,  0);
    chk("idle_s_scki", s_scki, 0);

    // stereo, H=4: bck period 8, lrck every 256, frame 512
    s_sel = 2'd1; s_en = 1'b1; k = 0;
    adv_to(1);
    chk("a1_fs", s_fs, 1); chk("a1_sel", s_act, 1); chk("a1_bck", s_bck, 0);
    chk("a1_scki", s_scki, 1); chk("a1_bit", s_bit, 0); chk("a1_lrck", s_lrck, 0);
`ifdef I2S_CLK_GEN_FRAME_CNT_EN
    chk("a1_fcnt", s_fcnt, 1);
`endif
    adv_to(2); chk("a2_fs", s_fs, 0); chk("a2_scki", s_scki, 0);
    adv_to(3); chk("a3_bck", s_bck, 0);
    adv_to(4); chk("a4_bck", s_bck, 1);
    adv_to(7); chk("a7_bck", s_bck, 1); chk("a7_bit", s_bit, 0);
    adv_to(8); chk("a8_bck", s_bck, 0); chk("a8_bit", s_bit, 1);
    adv_to(100);
    s_sel = 2'd0;
    adv_to(255); chk("a255_bit", s_bit, 31); chk("a255_lrck", s_lrck, 0); chk("a255_slot", s_slot, 0);
    adv_to(256); chk("a256_bit", s_bit, 0); chk("a256_slot", s_slot, 1); chk("a256_lrck", s_lrck, 1);
    chk("a256_fs", s_fs, 0);
    adv_to(511); chk("a511_sel", s_act, 1); chk("a511_fs", s_fs, 0); chk("a511_bck", s_bck, 1);
    adv_to(512); chk("a512_fs", s_fs, 1); chk("a512_sel", s_act, 0); chk("a512_slot", s_slot, 0);
    chk("a512_lrck", s_lrck, 0); chk("a512_bit", s_bit, 0); chk("a512_bck", s_bck, 0);
`ifdef I2S_CLK_GEN_FRAME_CNT_EN
    chk("a512_fcnt", s_fcnt, 2);
`endif
    adv_to(513); chk("a513_fs", s_fs, 0); chk("a513_bck", s_bck, 0);
    adv_to(514); chk("a514_bck", s_bck, 1);
    adv_to(516); chk("a516_bck", s_bck, 0); chk("a516_bit", s_bit, 1);
    adv_to(767); chk("a767_fs", s_fs, 0); chk("a767_bit", s_bit, 31); chk("a767_slot", s_slot, 1);
    adv_to(768); chk("a768_fs", s_fs, 1); chk("a768_lrck", s_lrck, 0);
    adv_to(896); chk("a896_slot", s_slot, 1); chk("a896_lrck", s_lrck, 1);

    // en dropped at slot 1 bit 5, held low 10 edges, new ratio sampled on restart
    adv_to(917); chk("b_pre_bit", s_bit, 5); chk("b_pre_slot", s_slot, 1);
    s_en = 1'b0; s_sel = 2'd2;
    adv_to(918);
    chk("b_idle_bit", s_bit, 0); chk("b_idle_slot", s_slot, 0); chk("b_idle_lrck", s_lrck, 0);
    chk("b_idle_sel", s_act, 1); chk("b_idle_scki", s_scki, 0); chk("b_idle_bck", s_bck, 0);
    adv_to(927); chk("b_hold_scki", s_scki, 0); chk("b_hold_fs", s_fs, 0); chk("b_hold_sel", s_act, 1);
    s_en = 1'b1; k = 0;
    adv_to(1); chk("c1_fs", s_fs, 1); chk("c1_sel", s_act, 2); chk("c1_scki", s_scki, 1);
    adv_to(7); chk("c7_bck", s_bck, 0);
    adv_to(8); chk("c8_bck", s_bck, 1);
    adv_to(15); chk("c15_bck", s_bck, 1);
    adv_to(16); chk("c16_bck", s_bck, 0); chk("c16_bit", s_bit, 1);

    // asynchronous reset mid-frame
    adv_to(301); chk("d301_bck", s_bck, 1); chk("d301_bit", s_bit, 18); chk("d301_scki", s_scki, 1);
    rst = 1'b1;
    #1;
    chk("d_rst_bck", s_bck, 0); chk("d_rst_scki", s_scki, 0); chk("d_rst_bit", s_bit, 0);
    chk("d_rst_sel", s_act, 1); chk("d_rst_fs", s_fs, 0);
    @(negedge mck);
    rst = 1'b0; k = 0;
    adv_to(1); chk("d1_fs", s_fs, 1); chk("d1_sel", s_act, 2); chk("d1_bck", s_bck, 0);
    adv_to(2); chk("d2_fs", s_fs, 0);
    s_en = 1'b0;

    // TDM 8x16, H=2: frame 512, lrck high for first 64 mck, scki = mck/4
    t_sel = 2'd0; t_en = 1'b1; k = 0;
    adv_to(1); chk("t1_fs", t_fs, 1); chk("t1_lrck", t_lrck, 1); chk("t1_sel", t_act, 0);
    chk("t1_scki", t_scki, 0); chk("t1_slot", t_slot, 0);
`ifdef I2S_CLK_GEN_FRAME_CNT_EN
    chk("t1_fcnt", t_fcnt, 1);
`endif
    adv_to(2); chk("t2_scki", t_scki, 1); chk("t2_bck", t_bck, 1);
    adv_to(3); chk("t3_scki", t_scki, 1);
    adv_to(4); chk("t4_scki", t_scki, 0); chk("t4_bck", t_bck, 0); chk("t4_bit", t_bit, 1);
    adv_to(63); chk("t63_bit", t_bit, 15); chk("t63_slot", t_slot, 0); chk("t63_lrck", t_lrck, 1);
    adv_to(64); chk("t64_bit", t_bit, 0); chk("t64_slot", t_slot, 1); chk("t64_lrck", t_lrck, 0);
    adv_to(511); chk("t511_slot", t_slot, 7); chk("t511_bit", t_bit, 15); chk("t511_fs", t_fs, 0);
    adv_to(512); chk("t512_fs", t_fs, 1); chk("t512_slot", t_slot, 0); chk("t512_lrck", t_lrck, 1);
    chk("t512_bit", t_bit, 0);
`ifdef I2S_CLK_GEN_FRAME_CNT_EN
    chk("t512_fcnt", t_fcnt, 2);
`endif
    adv_to(513); chk("t513_fs", t_fs, 0);
    adv_to(575); chk("t575_lrck", t_lrck, 1);
    adv_to(576); chk("t576_lrck", t_lrck, 0); chk("t576_slot", t_slot, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_clk_gen.md
Name: i2s_clk_gen

Overview:
Parametrised I2S/TDM clock generator and successor to the fixed-ratio master-clock divider. From the master clock it derives SCKI, BCK and LRCK/frame-sync. The BCK ratio is selectable at runtime and applied glitch-free at frame boundaries. It also exports bit/slot position and a frame strobe, so serialisers and deserialisers can align to it without their own counters.

Parameters:
SCKI_DIV_LOG2, 0, scki half-period = 2^SCKI_DIV_LOG2 mck cycles (0 gives scki = mck/2)
SLOT_BITS, 32, BCK cycles per channel slot; legal range >= 2
CHANNELS, 2, slots per frame; 2 = I2S stereo, >2 = TDM; legal range >= 2
BCK_SEL_RST, 1, value loaded into sel_active at reset and while idle

Ports:
mck  in  1  master clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  run enable; low = synchronous return to idle
bck_sel  in  2  requested BCK ratio; half-period H = 2^(bck_sel+1) mck, so BCK = mck/4, /8, /16, /32
scki  out  1  system clock to converter
bck  out  1  bit clock
lrck  out  1  word clock (stereo) or frame sync (TDM)
frame_start  out  1  one-mck pulse at frame boundary
slot_idx  out  max(1,$clog2(CHANNELS))  current slot
bit_idx  out  $clog2(SLOT_BITS)  current bit within slot, 0 = first bit
sel_active  out  2  ratio currently in effect

Behaviour:
- Reset (async, and also the idle state while en=0): all counters 0; scki=0, bck=0, lrck=0, frame_start=0, slot_idx=0, bit_idx=0; sel_active=BCK_SEL_RST.
- All outputs are registered; no combinational path from inputs to outputs.
- scki: free-running whenever en=1. A counter toggles scki every 2^SCKI_DIV_LOG2 mck. scki is independent of bck_sel.
- First enabled edge after idle: sel_active <= bck_sel; frame_start <= 1; div_cnt <= 1. This is bit 0 of slot 0.
- div_cnt counts 0..2H-1, with H taken from sel_active.
  - At the edge where div_cnt becomes H: bck <= 1.
  - At div_cnt = 2H-1, the next edge does div_cnt <= 0 and bck <= 0 (BCK falling edge), and bit_idx advances.
  - bck duty is exactly 50%.
- bit_idx wraps SLOT_BITS-1 -> 0 and advances slot_idx at that edge. slot_idx wraps CHANNELS-1 -> 0.
- Frame boundary = the BCK falling edge where slot_idx wraps to 0. At that same edge:
  - frame_start <= 1 for exactly one mck cycle;
  - sel_active <= bck_sel.
- bck_sel changes mid-frame are ignored until the next frame boundary. No runt BCK pulse is ever produced.
- lrck is updated on the same edge as slot_idx:
  - CHANNELS=2: lrck = slot_idx[0] (0 = left, 1 = right), 50% duty.
  - CHANNELS>2: lrck = 1 during slot 0 only (frame-sync pulse one slot wide), else 0.
- Frame length = 2H*SLOT_BITS*CHANNELS mck.
- en falling: on the next edge, all state returns to the idle values, regardless of position in the frame.
- reset mid-frame: outputs go to reset values immediately (asynchronous). Restart behaves as the first-enabled-edge case.
- Data alignment (I2S one-bit delay, left-justified) is the serialiser's responsibility. This block only marks BCK falling edges and positions.

Optional Feature:
I2S_CLK_GEN_FRAME_CNT_EN
- Defined:
  - adds output frame_cnt [15:0];
  - increments on every frame_start pulse, including the first after idle;
  - wraps 0xFFFF -> 0x0000;
  - cleared by reset and while en=0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- SLOT_BITS=32, CHANNELS=2, bck_sel=1, en=1 after reset -> bck period 8 mck with 4 high/4 low; lrck toggles every 256 mck; frame_start pulses every 512 mck, one cycle wide; scki period 2 mck.
- Same configuration, bck_sel changed 1->0 at mck 100 of frame 0 -> frame 0 keeps 8-mck BCK to mck 512; from the boundary, bck period 4 and frame length 256; sel_active changes exactly at the boundary.
- SLOT_BITS=16, CHANNELS=8, bck_sel=0 -> frame 512 mck; lrck high for the first 64 mck of each frame; slot_idx runs 0..7; bit_idx runs 0..15 per slot.
- reset pulsed high at mck 300 mid-frame -> all outputs 0 immediately; restart produces frame_start on the first edge after reset release.
- en dropped at bit_idx=5, slot 1, then raised 10 cycles later -> idle values held while low; fresh frame starts with frame_start=1 and new bck_sel sampled.
- With I2S_CLK_GEN_FRAME_CNT_EN, preload to 0xFFFE via 2^16-2 frames at bck_sel=0 (or force) -> frame_cnt reads 0xFFFF, then 0x0000 on the following frame_start.
